// File: rtl/mem_arb_if.sv
// Bus bundle for the IFU/LSU-to-memory arbiter.
// The slave modport is the arbiter's view. The master modport is the requester and memory side.
interface mem_arb_if #(
    parameter int XLEN = 64
);
    localparam int STRBW = XLEN / 8;

    // Instruction-fetch requester (read-only)
    logic             ifu_req;
    logic [XLEN-1:0]  ifu_addr;
    logic             ifu_ack;
    logic             ifu_err;
    logic [XLEN-1:0]  ifu_rdata;

    // Load/store requester
    logic             lsu_req;
    logic             lsu_we;
    logic [XLEN-1:0]  lsu_addr;
    logic [XLEN-1:0]  lsu_wdata;
    logic [STRBW-1:0] lsu_wstrb;
    logic             lsu_ack;
    logic             lsu_err;
    logic [XLEN-1:0]  lsu_rdata;

    // Shared memory port
    logic             mem_req;
    logic             mem_we;
    logic [XLEN-1:0]  mem_addr;
    logic [XLEN-1:0]  mem_wdata;
    logic [STRBW-1:0] mem_wstrb;
    logic             mem_ack;
    logic [XLEN-1:0]  mem_rdata;

    logic             owner;

    modport slave (
        input  ifu_req, ifu_addr,
        output ifu_ack, ifu_err, ifu_rdata,
        input  lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_wstrb,
        output lsu_ack, lsu_err, lsu_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ack, mem_rdata,
        output owner
    );

    modport master (
        output ifu_req, ifu_addr,
        input  ifu_ack, ifu_err, ifu_rdata,
        output lsu_req, lsu_we, lsu_addr, lsu_wdata, lsu_wstrb,
        input  lsu_ack, lsu_err, lsu_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ack, mem_rdata,
        input  owner
    );
endinterface

// File: rtl/mem_arb.sv
// Two-port memory arbiter. The LSU has fixed priority over the IFU, and a streak counter bounds that priority.
// A per-access timeout turns a hung memory access into an error response.
module mem_arb #(
    parameter int XLEN       = 64,
    parameter int MAX_STREAK = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic     clk_i,
    input  logic     reset_i,   // asynchronous, active-low
    mem_arb_if.slave bus
);
    localparam int         STRBW      = XLEN / 8;
    localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);
    localparam bit         TMO_EN     = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RESP
    } state_e;

    state_e           state_q;
    logic             mem_req_q;
    logic             mem_we_q;
    logic [XLEN-1:0]  mem_addr_q;
    logic [XLEN-1:0]  mem_wdata_q;
    logic [STRBW-1:0] mem_wstrb_q;
    logic             owner_q;
    logic             ifu_ack_q;
    logic             ifu_err_q;
    logic [XLEN-1:0]  ifu_rdata_q;
    logic             lsu_ack_q;
    logic             lsu_err_q;
    logic [XLEN-1:0]  lsu_rdata_q;
    logic [3:0]       streak_q;
    logic [7:0]       tmo_q;

    logic             any_req;
    logic             lsu_win;
    logic             tmo_fire;
    logic [3:0]       streak_d;
    logic [XLEN-1:0]  rdata_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        any_req  = bus.lsu_req | bus.ifu_req;
        lsu_win  = bus.lsu_req & ~(bus.ifu_req & (streak_q == STREAK_MAX));
        tmo_fire = TMO_EN && (tmo_q == TMO_LAST);
        streak_d = 4'd0;
        if (lsu_win && bus.ifu_req) begin
            streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 4'd1;
        end
        rdata_d = '0;
        if (bus.mem_ack && !mem_we_q) begin
            rdata_d = bus.mem_rdata;
        end
    end

    // NOTE: all state uses non-blocking assignments, so every read in this block sees the value from before the edge.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            owner_q     <= 1'b0;
            ifu_ack_q   <= 1'b0;
            ifu_err_q   <= 1'b0;
            ifu_rdata_q <= '0;
            lsu_ack_q   <= 1'b0;
            lsu_err_q   <= 1'b0;
            lsu_rdata_q <= '0;
            streak_q    <= 4'd0;
            tmo_q       <= 8'd0;
        end else begin
            ifu_ack_q <= 1'b0;
            lsu_ack_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (any_req) begin
                        state_q   <= S_ISSUE;
                        mem_req_q <= 1'b1;
                        owner_q   <= lsu_win;
                        streak_q  <= streak_d;
                        tmo_q     <= 8'd0;
                        if (lsu_win) begin
                            mem_we_q    <= bus.lsu_we;
                            mem_addr_q  <= bus.lsu_addr;
                            mem_wdata_q <= bus.lsu_wdata;
                            mem_wstrb_q <= bus.lsu_wstrb;
                        end else begin
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= bus.ifu_addr;
                            mem_wdata_q <= '0;
                            mem_wstrb_q <= '0;
                        end
                    end
                end
                S_ISSUE: begin
                    // A mem_ack beats a timeout that fires in the same cycle.
                    if (bus.mem_ack || tmo_fire) begin
                        state_q   <= S_RESP;
                        mem_req_q <= 1'b0;
                        if (owner_q) begin
                            lsu_ack_q   <= 1'b1;
                            lsu_err_q   <= ~bus.mem_ack;
                            lsu_rdata_q <= rdata_d;
                        end else begin
                            ifu_ack_q   <= 1'b1;
                            ifu_err_q   <= ~bus.mem_ack;
                            ifu_rdata_q <= rdata_d;
                        end
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wstrb = mem_wstrb_q;
    assign bus.owner     = owner_q;
    assign bus.ifu_ack   = ifu_ack_q;
    assign bus.ifu_err   = ifu_err_q;
    assign bus.ifu_rdata = ifu_rdata_q;
    assign bus.lsu_ack   = lsu_ack_q;
    assign bus.lsu_err   = lsu_err_q;
    assign bus.lsu_rdata = lsu_rdata_q;
endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: requester agents, a latency-programmable memory model and a per-requester scoreboard.
// One process drives everything, one step per clock, 1 time unit after the rising edge.
module tb_mem_arb;
    localparam int XLEN = 64;
    localparam int SW   = XLEN / 8;
    localparam int TMO  = 8;

    typedef logic [XLEN-1:0] word_t;
    typedef struct {
        bit          lsu;
        bit          we;
        word_t       addr;
        word_t       wdata;
        logic [SW-1:0] wstrb;
        int          lat;         // memory wait cycles before mem_ack
        word_t       exp_rdata;
        bit          exp_err;
        int          exp_lat;     // clock edges from request drive to ack; 0 = not checked
        int          exp_req_len; // cycles mem_req stays high
    } job_t;

    logic clk;
    logic rst_n;
    mem_arb_if #(.XLEN(XLEN)) bus();

    mem_arb #(.XLEN(XLEN), .MAX_STREAK(4), .TIMEOUT(TMO)) dut (
        .clk_i   (clk),
        .reset_i (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    job_t ifu_jobs[$], lsu_jobs[$], ifu_sb[$], lsu_sb[$];
    bit   ifu_busy, lsu_busy;
    int   ifu_t0, lsu_t0;
    bit   prev_mem_req, prev_ifu_ack, prev_lsu_ack;
    int   req_len, last_req_len;
    bit   grant_log[$];
    int   grant_cyc[$];
    int   mem_lat, mem_wait;
    bit   stray;

    task automatic check(input string name, input word_t act, input word_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    function automatic word_t rdata_for(input word_t a);
        return (a == 64'h100) ? 64'hDEAD_BEEF : {a[31:0], ~a[31:0]};
    endfunction

    function automatic bit outs_any();
        return |{bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb,
                 bus.ifu_ack, bus.ifu_err, bus.ifu_rdata,
                 bus.lsu_ack, bus.lsu_err, bus.lsu_rdata, bus.owner};
    endfunction

    function automatic job_t mk(input bit lsu, input bit we, input word_t addr, input word_t wdata,
                                input logic [SW-1:0] wstrb, input int lat, input word_t exp_rdata,
                                input bit exp_err, input int exp_lat, input int exp_req_len);
        job_t j;
        j.lsu = lsu; j.we = we; j.addr = addr; j.wdata = wdata; j.wstrb = wstrb; j.lat = lat;
        j.exp_rdata = exp_rdata; j.exp_err = exp_err; j.exp_lat = exp_lat; j.exp_req_len = exp_req_len;
        return j;
    endfunction

    task automatic monitor();
        job_t j;
        if (bus.mem_req) begin
            if (!prev_mem_req) begin
                grant_log.push_back(bus.owner);
                grant_cyc.push_back(cyc);
                req_len = 0;
            end
            req_len++;
            if (bus.owner ? (lsu_sb.size() == 0) : (ifu_sb.size() == 0)) begin
                fail_now("grant_without_request");
            end else begin
                j = bus.owner ? lsu_sb[0] : ifu_sb[0];
                check("mem_we", word_t'(bus.mem_we), word_t'(j.we));
                check("mem_addr", bus.mem_addr, j.addr);
                check("mem_wstrb", word_t'(bus.mem_wstrb), word_t'(j.wstrb));
                if (j.lsu) check("mem_wdata", bus.mem_wdata, j.wdata);
            end
        end else if (prev_mem_req) begin
            last_req_len = req_len;
        end
        if (bus.ifu_ack && bus.lsu_ack) fail_now("both_acks_high");
        if (bus.ifu_ack) begin
            check("ifu_ack_single_pulse", word_t'(prev_ifu_ack), 0);
            if (ifu_sb.size() == 0) fail_now("ifu_ack_unexpected");
            else begin
                j = ifu_sb.pop_front();
                check("ifu_rdata", bus.ifu_rdata, j.exp_rdata);
                check("ifu_err", word_t'(bus.ifu_err), word_t'(j.exp_err));
                if (j.exp_lat > 0) check("ifu_latency", word_t'(cyc - ifu_t0), word_t'(j.exp_lat));
            end
        end
        if (bus.lsu_ack) begin
            check("lsu_ack_single_pulse", word_t'(prev_lsu_ack), 0);
            if (lsu_sb.size() == 0) fail_now("lsu_ack_unexpected");
            else begin
                j = lsu_sb.pop_front();
                check("lsu_rdata", bus.lsu_rdata, j.exp_rdata);
                check("lsu_err", word_t'(bus.lsu_err), word_t'(j.exp_err));
                if (j.exp_lat > 0) check("lsu_latency", word_t'(cyc - lsu_t0), word_t'(j.exp_lat));
            end
        end
        prev_mem_req = bus.mem_req;
        prev_ifu_ack = bus.ifu_ack;
        prev_lsu_ack = bus.lsu_ack;
    endtask

    // Memory returns data after mem_lat wait cycles; rdata is garbage whenever it is not acking.
    task automatic drive_mem();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        if (bus.mem_req) begin
            if (mem_wait == mem_lat) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = rdata_for(bus.mem_addr);
            end
            mem_wait++;
        end else begin
            mem_wait = 0;
            if (stray) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = rdata_for(64'h40);
                stray         = 1'b0;
            end
        end
    endtask

    // Each requester holds req through its ack cycle and presents the next job in the following cycle.
    task automatic drive_agents();
        job_t j;
        if (!ifu_busy) begin
            if (ifu_jobs.size() > 0) begin
                j = ifu_jobs.pop_front();
                bus.ifu_req  = 1'b1;
                bus.ifu_addr = j.addr;
                ifu_sb.push_back(j);
                ifu_t0   = cyc;
                ifu_busy = 1'b1;
            end else bus.ifu_req = 1'b0;
        end else if (bus.ifu_ack) ifu_busy = 1'b0;
        else if (cyc - ifu_t0 > 300) begin
            fail_now("ifu_ack_never_arrived");
            ifu_busy = 1'b0;
            ifu_sb.delete();
        end
        if (!lsu_busy) begin
            if (lsu_jobs.size() > 0) begin
                j = lsu_jobs.pop_front();
                bus.lsu_req   = 1'b1;
                bus.lsu_we    = j.we;
                bus.lsu_addr  = j.addr;
                bus.lsu_wdata = j.wdata;
                bus.lsu_wstrb = j.wstrb;
                lsu_sb.push_back(j);
                lsu_t0   = cyc;
                lsu_busy = 1'b1;
            end else bus.lsu_req = 1'b0;
        end else if (bus.lsu_ack) lsu_busy = 1'b0;
        else if (cyc - lsu_t0 > 300) begin
            fail_now("lsu_ack_never_arrived");
            lsu_busy = 1'b0;
            lsu_sb.delete();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        monitor();
        drive_mem();
        drive_agents();
    endtask

    task automatic reset_agents();
        ifu_jobs.delete(); lsu_jobs.delete(); ifu_sb.delete(); lsu_sb.delete();
        ifu_busy = 1'b0; lsu_busy = 1'b0;
        bus.ifu_req = 1'b0; bus.lsu_req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((ifu_busy || lsu_busy || ifu_jobs.size() > 0 || lsu_jobs.size() > 0 ||
                bus.ifu_req || bus.lsu_req) && n < 600) begin
            tick();
            n++;
        end
        if (n >= 600) fail_now({name, "_drain_timeout"});
        tick();
        tick();
    endtask

    job_t vec[8];
    bit   exp_order[10];
    int   n_grants;

    initial begin
        rst_n = 1'b0;
        bus.ifu_req = 1'b0; bus.ifu_addr = '0;
        bus.lsu_req = 1'b0; bus.lsu_we = 1'b0; bus.lsu_addr = '0; bus.lsu_wdata = '0; bus.lsu_wstrb = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        ifu_busy = 0; lsu_busy = 0; prev_mem_req = 0; prev_ifu_ack = 0; prev_lsu_ack = 0;
        req_len = 0; last_req_len = -1; mem_lat = 0; mem_wait = 0; stray = 0;

        vec[0] = mk(0, 0, 64'h100,  64'h0, 8'h00, 2,   64'hDEAD_BEEF,           0, 4, 3);
        vec[1] = mk(1, 1, 64'h80,   64'h7, 8'hFF, 0,   64'h0,                   0, 2, 1);
        vec[2] = mk(1, 0, 64'h2000, 64'h0, 8'h00, 1,   64'h0000_2000_FFFF_DFFF, 0, 3, 2);
        vec[3] = mk(1, 1, 64'h88,   64'h1122_3344_5566_7788, 8'h0F, 3, 64'h0,   0, 5, 4);
        vec[4] = mk(0, 0, 64'h3008, 64'h0, 8'h00, 7,   64'h0000_3008_FFFF_CFF7, 0, 9, 8);
        vec[5] = mk(1, 0, 64'h40,   64'h0, 8'h00, 255, 64'h0,                   1, 9, 8);
        vec[6] = mk(0, 0, 64'h48,   64'h0, 8'h00, 255, 64'h0,                   1, 9, 8);
        vec[7] = mk(1, 1, 64'h50,   64'h99, 8'hF0, 8,  64'h0,                   1, 9, 8);
        exp_order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

        // Reset state, then both requesters present when reset releases
        repeat (2) tick();
        check("reset_outputs_zero", word_t'(outs_any()), 0);
        ifu_jobs.push_back(mk(0, 0, 64'h200, 64'h0, 8'h00, 0, rdata_for(64'h200), 0, 0, 1));
        lsu_jobs.push_back(mk(1, 0, 64'h300, 64'h0, 8'h00, 0, rdata_for(64'h300), 0, 0, 1));
        tick();
        check("outputs_zero_with_reqs_in_reset", word_t'(outs_any()), 0);
        rst_n = 1'b1;
        grant_log.delete();
        wait_idle("release");
        check("release_grant_count", word_t'(grant_log.size()), 2);
        if (grant_log.size() >= 2) begin
            check("release_first_grant_lsu", word_t'(grant_log[0]), 1);
            check("release_second_grant_ifu", word_t'(grant_log[1]), 0);
        end

        // Single-transaction vectors
        for (int i = 0; i < 8; i++) begin
            grant_log.delete();
            last_req_len = -1;
            mem_lat = vec[i].lat;
            if (vec[i].lsu) lsu_jobs.push_back(vec[i]);
            else ifu_jobs.push_back(vec[i]);
            wait_idle("vector");
            check("vec_grant_count", word_t'(grant_log.size()), 1);
            if (grant_log.size() >= 1) check("vec_owner", word_t'(grant_log[0]), word_t'(vec[i].lsu));
            check("vec_owner_output", word_t'(bus.owner), word_t'(vec[i].lsu));
            check("vec_mem_req_cycles", word_t'(last_req_len), word_t'(vec[i].exp_req_len));
        end

        // Starvation bound with both sides requesting continuously
        mem_lat = 0;
        for (int i = 0; i < 10; i++) begin
            ifu_jobs.push_back(mk(0, 0, 64'h1000 + 64'(8 * i), 64'h0, 8'h00, 0,
                                  rdata_for(64'h1000 + 64'(8 * i)), 0, 0, 1));
            lsu_jobs.push_back(mk(1, 0, 64'h4000 + 64'(8 * i), 64'h0, 8'h00, 0,
                                  rdata_for(64'h4000 + 64'(8 * i)), 0, 0, 1));
        end
        grant_log.delete();
        grant_cyc.delete();
        wait_idle("starve");
        n_grants = grant_log.size();
        check("starve_grant_count", word_t'(n_grants), 20);
        if (n_grants >= 10) begin
            for (int i = 0; i < 10; i++) check("starve_grant_order", word_t'(grant_log[i]), word_t'(exp_order[i]));
            for (int i = 1; i < 10; i++) check("starve_grant_spacing", word_t'(grant_cyc[i] - grant_cyc[i-1]), 3);
        end

        // Stray mem_ack while idle must be ignored
        grant_log.delete();
        stray = 1'b1;
        repeat (4) begin
            tick();
            check("stray_no_mem_req", word_t'(bus.mem_req), 0);
            check("stray_no_ack", word_t'(bus.ifu_ack | bus.lsu_ack), 0);
        end
        mem_lat = 1;
        ifu_jobs.push_back(mk(0, 0, 64'h600, 64'h0, 8'h00, 1, rdata_for(64'h600), 0, 3, 2));
        wait_idle("after_stray");
        check("after_stray_grants", word_t'(grant_log.size()), 1);

        // Reset in the middle of an ISSUE phase
        mem_lat = 255;
        lsu_jobs.push_back(mk(1, 0, 64'h500, 64'h0, 8'h00, 255, 64'h0, 1, 0, 8));
        begin
            int n = 0;
            while (!bus.mem_req && n < 20) begin
                tick();
                n++;
            end
            check("midreset_issue_reached", word_t'(bus.mem_req), 1);
        end
        tick();
        rst_n = 1'b0;
        #1;
        check("midreset_async_outputs_zero", word_t'(outs_any()), 0);
        reset_agents();
        repeat (3) begin
            tick();
            check("midreset_outputs_zero", word_t'(outs_any()), 0);
        end
        rst_n = 1'b1;
        repeat (5) begin
            tick();
            check("post_reset_mem_req_idle", word_t'(bus.mem_req), 0);
        end
        mem_lat = 0;
        lsu_jobs.push_back(mk(1, 1, 64'h700, 64'hABCD, 8'h3C, 0, 64'h0, 0, 2, 1));
        wait_idle("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
